// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad scanner.
// decode_key turns a column index and an active-high row vector into a key code.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Lowest asserted row wins when several rows are active in one column.
    function automatic logic [3:0] decode_key(input logic [1:0] col_idx,
                                              input logic [3:0] row_onehot);
        logic [1:0] row_idx;
        logic [3:0] code;
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_onehot[i]) row_idx = 2'(i);
        end
        case ({row_idx, col_idx})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/row_synchronizer.sv
// Multi-stage flop synchronizer for the asynchronous keypad row lines.
// Resets to the idle (all-high) pattern so no phantom key is seen after reset.
module row_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= RESET_VAL;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, press/release debounce and key decode.
// The column is frozen from first detection until the key is released.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clock50MHz,
    input  logic       reset,
    input  logic [3:0] Rows,
    output logic [3:0] Columns,
    output logic [3:0] KeypadData,
    output logic       dav,
    output logic       KeyStrobe,
    output logic [1:0] PresentStateFlag
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] deb_q, deb_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    data_q, data_d;
    logic          dav_q, dav_d;
    logic          strobe_q, strobe_d;
    logic [3:0]    rs;

    row_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (4),
        .RESET_VAL   (4'hF)
    ) u_row_sync (
        .clk   (clock50MHz),
        .rst_n (reset),
        .din   (Rows),
        .dout  (rs)
    );

    always_ff @(posedge clock50MHz or negedge reset) begin
        if (!reset) begin
            state_q  <= SCAN;
            col_q    <= 2'd0;
            dwell_q  <= '0;
            deb_q    <= '0;
            pat_q    <= 4'hF;
            data_q   <= 4'h0;
            dav_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            dwell_q  <= dwell_d;
            deb_q    <= deb_d;
            pat_q    <= pat_d;
            data_q   <= data_d;
            dav_q    <= dav_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        dwell_d  = dwell_q;
        deb_d    = deb_q;
        pat_d    = pat_q;
        data_d   = data_q;
        dav_d    = dav_q;
        strobe_d = 1'b0;
        unique case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (rs == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        pat_d   = rs;
                        deb_d   = '0;
                        state_d = DEB_PRESS;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (rs == 4'hF) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end else if (rs != pat_q) begin
                    // A different row pattern restarts the debounce window.
                    pat_d = rs;
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d  = PRESSED;
                    deb_d    = '0;
                    data_d   = decode_key(col_q, ~rs);
                    dav_d    = 1'b1;
                    strobe_d = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            PRESSED: begin
                if (rs == 4'hF) begin
                    state_d = DEB_RELEASE;
                    deb_d   = '0;
                end
            end
            DEB_RELEASE: begin
                if (rs != 4'hF) begin
                    state_d = PRESSED;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = SCAN;
                    dav_d   = 1'b0;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign Columns          = ~(4'b0001 << col_q);
    assign KeypadData       = data_q;
    assign dav              = dav_q;
    assign KeyStrobe        = strobe_q;
    assign PresentStateFlag = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus pushes expected key codes,
// a monitor pops and compares them on every KeyStrobe pulse.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  Rows;
    logic [3:0]  Columns;
    logic [3:0]  KeypadData;
    logic        dav;
    logic        KeyStrobe;
    logic [1:0]  PresentStateFlag;
    logic [15:0] keys;   // bit r*4+c set = key at row r, column c held down

    int tests;
    int fails;
    int strobe_cnt;
    logic [3:0] exp_q[$];

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2)
    ) dut (
        .clock50MHz       (clk),
        .reset            (reset),
        .Rows             (Rows),
        .Columns          (Columns),
        .KeypadData       (KeypadData),
        .dav              (dav),
        .KeyStrobe        (KeyStrobe),
        .PresentStateFlag (PresentStateFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a held key pulls its row low only while its column is driven low.
    always_comb begin
        Rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !Columns[c]) Rows[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (reset && KeyStrobe === 1'b1) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(KeyStrobe), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_code", 32'(KeypadData), 32'(e));
                    check("strobe_dav", 32'(dav), 32'd1);
                end
            end
        end
    endtask

    task automatic wait_dav(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (dav !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(dav), 32'(lvl));
    endtask

    task automatic wait_col(input logic [3:0] col, input int budget, input string name);
        int n;
        n = 0;
        while (Columns !== col && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(Columns), 32'(col));
    endtask

    initial begin
        logic [3:0] ecol;
        logic       bad;
        int         s0;
        tests = 0;
        fails = 0;
        strobe_cnt = 0;
        keys = 16'h0;
        reset = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_columns", 32'(Columns), 32'hE);
        check("rst_dav", 32'(dav), 32'd0);
        check("rst_strobe", 32'(KeyStrobe), 32'd0);
        check("rst_data", 32'(KeypadData), 32'h0);
        check("rst_state", 32'(PresentStateFlag), 32'd0);

        // Idle scan: each column low for 4 cycles, wrapping back to column 0.
        reset = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            ecol = ~(4'b0001 << ((k / 4) % 4));
            check("scan_rotate", 32'(Columns), 32'(ecol));
            @(negedge clk);
        end

        // Clean press of '6' held for 40 cycles.
        s0 = strobe_cnt;
        keys[6] = 1'b1;
        exp_q.push_back(4'h6);
        wait_dav(1'b1, 100, "press6_dav");
        check("press6_state", 32'(PresentStateFlag), 32'd2);
        check("press6_cols", 32'(Columns), 32'hB);
        check("press6_data", 32'(KeypadData), 32'h6);
        repeat (40) @(negedge clk);
        check("press6_one_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("press6_hold_dav", 32'(dav), 32'd1);
        keys = 16'h0;
        wait_dav(1'b0, 100, "rel6_dav");
        check("rel6_cols", 32'(Columns), 32'h7);

        // Bouncy '*' press starting at the column-0 dwell.
        wait_col(4'hE, 40, "star_col0");
        exp_q.push_back(4'hE);
        s0 = strobe_cnt;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keys[12] = (i % 2 == 0);
            @(negedge clk);
            if (dav) bad = 1'b1;
        end
        keys[12] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (dav) bad = 1'b1;
        end
        check("star_no_early_dav", 32'(bad), 32'd0);
        wait_dav(1'b1, 200, "star_dav");
        check("star_data", 32'(KeypadData), 32'hE);
        repeat (20) @(negedge clk);
        check("star_one_strobe", 32'(strobe_cnt - s0), 32'd1);
        keys = 16'h0;
        wait_dav(1'b0, 100, "star_rel_dav");

        // '#' held, then released with three short glitches.
        keys[14] = 1'b1;
        exp_q.push_back(4'hF);
        wait_dav(1'b1, 100, "hash_dav");
        check("hash_data", 32'(KeypadData), 32'hF);
        @(negedge clk);
        s0 = strobe_cnt;
        keys[14] = 1'b0;
        bad = 1'b0;
        for (int g = 0; g < 3; g++) begin
            repeat (4) begin
                @(negedge clk);
                if (!dav) bad = 1'b1;
            end
            keys[14] = 1'b1;
            @(negedge clk);
            if (!dav) bad = 1'b1;
            keys[14] = 1'b0;
        end
        check("hash_glitch_dav_held", 32'(bad), 32'd0);
        wait_dav(1'b0, 100, "hash_rel_dav");
        check("hash_rel_cols", 32'(Columns), 32'h7);
        check("hash_rel_data_kept", 32'(KeypadData), 32'hF);
        check("hash_rel_state", 32'(PresentStateFlag), 32'd0);
        check("hash_no_extra_strobe", 32'(strobe_cnt - s0), 32'd0);

        // '1' and '4' together in column 0: row 0 wins.
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        exp_q.push_back(4'h1);
        wait_dav(1'b1, 100, "two_same_dav");
        check("two_same_data", 32'(KeypadData), 32'h1);
        keys = 16'h0;
        wait_dav(1'b0, 100, "two_same_rel");

        // Scan now sits at column 1: '2' (c1) is found before 'C' (c3).
        keys[1] = 1'b1;
        keys[11] = 1'b1;
        exp_q.push_back(4'h2);
        wait_dav(1'b1, 100, "two_diff_dav");
        check("two_diff_data", 32'(KeypadData), 32'h2);
        check("two_diff_cols", 32'(Columns), 32'hD);
        keys = 16'h0;
        wait_dav(1'b0, 100, "two_diff_rel");

        // Reset while 'A' is held, then a fresh press after reset release.
        keys[3] = 1'b1;
        exp_q.push_back(4'hA);
        wait_dav(1'b1, 100, "a_dav");
        check("a_data", 32'(KeypadData), 32'hA);
        #2 reset = 1'b0;
        #1;
        check("a_rst_dav", 32'(dav), 32'd0);
        check("a_rst_data", 32'(KeypadData), 32'h0);
        check("a_rst_state", 32'(PresentStateFlag), 32'd0);
        check("a_rst_cols", 32'(Columns), 32'hE);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(4'hA);
        wait_dav(1'b1, 150, "a_again_dav");
        check("a_again_data", 32'(KeypadData), 32'hA);
        keys = 16'h0;
        wait_dav(1'b0, 100, "a_rel_dav");
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
